// File: rtl/float_byte_reader.sv
// Captures a 32-bit float result and shows it one byte at a time on LEDs and 7-seg.
// Optional FLOAT_READER_LOAD_SYNC_EN adds a two-flop synchronizer on load.
module float_byte_reader #(
   parameter int SCAN_DIV = 100000,
   parameter int AUTO_DIV = 100000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] val,
   input  logic        mode,
   input  logic [1:0]  seldata,
   output logic [7:0]  byte_out,
   output logic [1:0]  byte_idx,
   output logic        valid,
   output logic [3:0]  leds,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int AW = $clog2(AUTO_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [AW-1:0] AMAX = AW'(AUTO_DIV - 1);
   localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] BLANK = 7'h7F;

   typedef enum logic {IDLE, SHOW} state_t;

   state_t          state_q, state_d;
   logic            load_in, load_q, rise;
   logic [31:0]     word_q, word_d;
   logic [1:0]      idx_q, idx_d;
   logic [AW-1:0]   acnt_q, acnt_d;
   logic [7:0]      byte_q, byte_d;
   logic [3:0]      leds_q, leds_d;
   logic [SW-1:0]   scnt_q, scnt_d;
   logic [1:0]      dig_q, dig_d;
   logic [3:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;

`ifdef FLOAT_READER_LOAD_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= load;
         sync2_q <= sync1_q;
      end
   end

   assign load_in = sync2_q;
`else
   assign load_in = load;
`endif

   assign rise = load_in & ~load_q;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (rise) state_d = SHOW;
   end

   // FSM: outputs
   always_comb begin
      valid = (state_q == SHOW);
   end

   // A load rise wins over an auto step landing on the same edge.
   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      acnt_d = acnt_q;
      if (rise) begin
         word_d = val;
         idx_d  = 2'd3;
         acnt_d = '0;
      end else if (state_q == SHOW) begin
         if (mode) begin
            idx_d  = seldata;
            acnt_d = '0;
         end else if (acnt_q == AMAX) begin
            idx_d  = idx_q - 2'd1;
            acnt_d = '0;
         end else begin
            acnt_d = acnt_q + 1'b1;
         end
      end
      byte_d = word_q[8*idx_q +: 8];
      leds_d = (state_d == SHOW) ? (4'b0001 << idx_d) : 4'b0000;
   end

   always_comb begin
      scnt_d = (scnt_q == SMAX) ? '0 : scnt_q + 1'b1;
      dig_d  = (scnt_q == SMAX) ? dig_q + 2'd1 : dig_q;
      an_d   = ~(4'b0001 << dig_d);
      seg_d  = DASH;
      if (state_q == SHOW) begin
         case (dig_d)
            2'd0:    seg_d = hex7(byte_q[3:0]);
            2'd1:    seg_d = hex7(byte_q[7:4]);
            2'd2:    seg_d = BLANK;
            default: seg_d = hex7({2'b00, idx_q});
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         load_q <= 1'b0;
         word_q <= '0;
         idx_q  <= '0;
         acnt_q <= '0;
         byte_q <= '0;
         leds_q <= '0;
         scnt_q <= '0;
         dig_q  <= '0;
         an_q   <= 4'b1110;
         seg_q  <= DASH;
      end else begin
         load_q <= load_in;
         word_q <= word_d;
         idx_q  <= idx_d;
         acnt_q <= acnt_d;
         byte_q <= byte_d;
         leds_q <= leds_d;
         scnt_q <= scnt_d;
         dig_q  <= dig_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign byte_out = byte_q;
   assign byte_idx = idx_q;
   assign leds     = leds_q;
   assign an       = an_q;
   assign seg      = seg_q;

endmodule

// File: tb/tb_float_byte_reader.sv
// Self-checking bench for float_byte_reader with SCAN_DIV=4, AUTO_DIV=8.
// Expected bytes are queued on stimulus and popped when byte_out should show them.
module tb_float_byte_reader;

   localparam int SD = 4;
   localparam int AD = 8;
`ifdef FLOAT_READER_LOAD_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif
   localparam logic [6:0] DASH = 7'b0111111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [31:0] val = '0;
   logic        mode = 1'b1;
   logic [1:0]  seldata = '0;
   logic [7:0]  byte_out;
   logic [1:0]  byte_idx;
   logic        valid;
   logic [3:0]  leds;
   logic [3:0]  an;
   logic [6:0]  seg;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];

   float_byte_reader #(.SCAN_DIV(SD), .AUTO_DIV(AD)) dut (
      .clk(clk), .reset(reset), .load(load), .val(val),
      .mode(mode), .seldata(seldata), .byte_out(byte_out),
      .byte_idx(byte_idx), .valid(valid), .leds(leds),
      .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the scan to move onto digit d, so seg reflects settled data.
   task automatic find_digit(input int d, output bit found);
      logic [3:0] tgt, prev;
      tgt = ~(4'b0001 << d);
      prev = an;
      found = 1'b0;
      for (int i = 0; i < 6 * SD; i++) begin
         tick();
         if (an === tgt && prev !== tgt) begin
            found = 1'b1;
            break;
         end
         prev = an;
      end
   endtask

   task automatic pop_check(input string nm);
      logic [7:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty, got %h", nm, byte_out);
      end else begin
         e = exp_q.pop_front();
         if (byte_out !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, byte_out, e);
         end
      end
   endtask

   task automatic check_seg(input int d, input logic [6:0] e, input string nm);
      bit f;
      find_digit(d, f);
      n_cmp++;
      if (!f) begin
         n_bad++;
         $display("FAIL %s: digit %0d never scanned", nm, d);
      end else if (seg !== e) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", nm, seg, e);
      end
   endtask

   task automatic test_reset();
      logic [3:0] ea;
      reset = 1'b1;
      load = 1'b0;
      tick();
      reset = 1'b0;
      n_cmp++;
      if (valid !== 1'b0 || leds !== 4'b0 || byte_out !== 8'h00 || byte_idx !== 2'd0) begin
         n_bad++;
         $display("FAIL rst_out: got v=%b l=%b b=%h i=%0d want 0", valid, leds, byte_out, byte_idx);
      end
      for (int j = 0; j < 4 * SD; j++) begin
         if (j > 0) tick();
         ea = ~(4'b0001 << ((j / SD) % 4));
         n_cmp++;
         if (an !== ea || seg !== DASH) begin
            n_bad++;
            $display("FAIL rst_scan[%0d]: got an=%b seg=%b want an=%b seg=%b", j, an, seg, ea, DASH);
         end
      end
   endtask

   task automatic test_capture();
      mode = 1'b1;
      seldata = 2'd3;
      val = 32'h40490FDB;
      load = 1'b1;
      exp_q.push_back(8'h40);
      repeat (1 + SL) tick();
      load = 1'b0;
      n_cmp++;
      if (valid !== 1'b1 || byte_idx !== 2'd3 || leds !== 4'b1000) begin
         n_bad++;
         $display("FAIL cap_state: got v=%b i=%0d l=%b want 1 3 1000", valid, byte_idx, leds);
      end
      tick();
      pop_check("cap_byte");
      check_seg(1, 7'b0011001, "cap_dig1");
      check_seg(0, 7'b1000000, "cap_dig0");
      check_seg(2, 7'h7F, "cap_dig2");
      check_seg(3, 7'b0110000, "cap_dig3");
   endtask

   task automatic test_manual();
      logic [1:0]  sel[3];
      logic [7:0]  eb[3];
      logic [6:0]  es[3];
      logic [7:0]  prev;
      sel = '{2'd2, 2'd1, 2'd0};
      eb  = '{8'h49, 8'h0F, 8'hDB};
      es  = '{7'b0100100, 7'b1111001, 7'b1000000};
      for (int k = 0; k < 3; k++) begin
         prev = byte_out;
         seldata = sel[k];
         exp_q.push_back(eb[k]);
         tick();
         n_cmp++;
         if (byte_idx !== sel[k] || byte_out !== prev) begin
            n_bad++;
            $display("FAIL man_lat[%0d]: got i=%0d b=%h want i=%0d b=%h", k, byte_idx, byte_out, sel[k], prev);
         end
         tick();
         pop_check("man_byte");
         check_seg(3, es[k], "man_dig3");
      end
   endtask

   task automatic test_auto();
      logic [1:0] ei[5];
      logic [7:0] eb[5];
      ei = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
      eb = '{8'h40, 8'h49, 8'h0F, 8'hDB, 8'h40};
      mode = 1'b0;
      val = 32'h40490FDB;
      load = 1'b1;
      repeat (1 + SL) tick();
      load = 1'b0;
      for (int k = 0; k < 5; k++) exp_q.push_back(eb[k]);
      n_cmp++;
      if (byte_idx !== 2'd3) begin
         n_bad++;
         $display("FAIL auto_cap: got %0d want 3", byte_idx);
      end
      for (int t = 1; t <= 4 * AD + 1; t++) begin
         tick();
         if (t % AD == 0) begin
            n_cmp++;
            if (byte_idx !== ei[t / AD]) begin
               n_bad++;
               $display("FAIL auto_idx t=%0d: got %0d want %0d", t, byte_idx, ei[t / AD]);
            end
         end else if (t % AD == AD - 1) begin
            n_cmp++;
            if (byte_idx !== ei[t / AD]) begin
               n_bad++;
               $display("FAIL auto_hold t=%0d: got %0d want %0d", t, byte_idx, ei[t / AD]);
            end
         end else if (t % AD == 1) begin
            pop_check("auto_byte");
         end
      end
   endtask

   // Continues the auto timeline: terminal count lands on the edge at t=40.
   task automatic test_recapture();
      repeat (AD - 2 - SL) tick();
      val = 32'hC1200000;
      load = 1'b1;
      repeat (1 + SL) tick();
      load = 1'b0;
      exp_q.push_back(8'hC1);
      n_cmp++;
      if (byte_idx !== 2'd3) begin
         n_bad++;
         $display("FAIL recap_idx: got %0d want 3", byte_idx);
      end
      tick();
      pop_check("recap_byte");
      repeat (AD - 2) tick();
      n_cmp++;
      if (byte_idx !== 2'd3) begin
         n_bad++;
         $display("FAIL recap_hold: got %0d want 3", byte_idx);
      end
      exp_q.push_back(8'h20);
      tick();
      n_cmp++;
      if (byte_idx !== 2'd2) begin
         n_bad++;
         $display("FAIL recap_step: got %0d want 2", byte_idx);
      end
      tick();
      pop_check("recap_step_byte");
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if (byte_out !== 8'h00 || byte_idx !== 2'd0 || valid !== 1'b0 ||
          leds !== 4'b0 || an !== 4'b1110 || seg !== DASH) begin
         n_bad++;
         $display("FAIL mid_rst: got b=%h i=%0d v=%b l=%b an=%b seg=%b",
                  byte_out, byte_idx, valid, leds, an, seg);
      end
      mode = 1'b1;
      seldata = 2'd3;
      val = 32'h40490FDB;
      load = 1'b1;
      exp_q.push_back(8'h40);
      repeat (1 + SL) tick();
      load = 1'b0;
      n_cmp++;
      if (valid !== 1'b1 || byte_idx !== 2'd3 || leds !== 4'b1000) begin
         n_bad++;
         $display("FAIL mid_cap: got v=%b i=%0d l=%b want 1 3 1000", valid, byte_idx, leds);
      end
      tick();
      pop_check("mid_byte");
   endtask

   initial begin
      test_reset();
      test_capture();
      test_manual();
      test_auto();
      test_recapture();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
